vga_sprite_compositor: RTL
==========================

// Module: vga_sprite_compositor
// PURPOSE
//  Parametrised, pipelined successor to the fixed five-ship pixel colouring logic. Sits between the VGA timing generator and the DAC pins.
//  Composites the playfield, one player sprite and NUM_SPRITES ship sprites into 12-bit RGB.
//  Sprite attributes are double-buffered, so the game FSM can update them at any time without tearing.
//  An internal frame counter drives sprite blinking and a hit-flash timer.
// PARAMETERS
//  NUM_SPRITES   5    number of ship sprites (1..16)
//  COORD_W       16   width of pixel coordinates and sprite x/y/width
//  FLASH_FRAMES  30   frames the border stays dark after a hit_pulse
//  BLINK_SHIFT   3    frame-counter bit that sets blink phase (period 2^(BLINK_SHIFT+1) frames)
// PORTS
//  clk          in   1        pixel clock
//  rst          in   1        asynchronous, active-high reset
//  pix_valid    in   1        xcoord/ycoord are inside the visible area
//  xcoord       in   COORD_W  current pixel x
//  ycoord       in   COORD_W  current pixel y
//  frame_start  in   1        1-cycle pulse at the start of vertical blank
//  game         in   1        game running; enables hit flash
//  hit_pulse    in   1        1-cycle pulse that (re)starts the border flash
//  pxcoord      in   COORD_W  player top-left x (sprite is 16x16)
//  pycoord      in   COORD_W  player top-left y
//  wr_en        in   1        write the sprite attribute shadow registers
//  wr_idx       in   4        sprite index; writes with wr_idx >= NUM_SPRITES are dropped
//  wr_x, wr_y   in   COORD_W  sprite top-left
//  wr_w         in   COORD_W  sprite width minus 1 (body spans x..x+w)
//  wr_mode      in   2        OFF / SHIP / CORE / BLINK (enum in package)
//  flash_active out  1        flash timer is non-zero
//  rgb_valid    out  1        pix_valid delayed 2 cycles
//  vgaRed       out  4        colour channels; all 0 when rgb_valid = 0
//  vgaGreen     out  4
//  vgaBlue      out  4
// BEHAVIOUR
//  Reset: all outputs 0, shadow and active modes OFF, coordinates 0, frame_cnt 0, flash_cnt 0.
//  Attributes: a wr_en write lands in shadow[wr_idx] on the next edge.
//   - On frame_start, all shadows are copied to the active set.
//   - If wr_en and frame_start occur together, the copy takes the OLD shadow value; the new write appears one frame later.
//  frame_cnt (8b) increments on each frame_start and wraps freely. blink = frame_cnt[BLINK_SHIFT].
//  Flash: hit_pulse && game loads flash_cnt = FLASH_FRAMES.
//   - Otherwise, each frame_start decrements flash_cnt while it is non-zero.
//   - If hit_pulse and frame_start coincide, the load wins.
//   - A hit while the flash is active restarts the count.
//   - Deasserting game clears flash_cnt on the next edge.
//  Pipeline (latency 2): stage 1 registers per-object hit flags; stage 2 registers the prioritised colour.
//   - Pixels do not stall; pix_valid = 0 bubbles pass through as black.
//  Geometry: all right/bottom bounds are computed at COORD_W+1 bits, so x+w never wraps.
//   - Body: x..x+w, y..y+9.
//   - Core: cx = x + (w>>1); columns cx-4..cx+4, rows y+1..y+8. The left bound saturates at 0.
//  Mode: OFF draws nothing. SHIP draws body and core. CORE draws the core only. BLINK draws as SHIP when blink = 1, else nothing.
//  Priority, high to low:
//   1. player (RED|GREEN)
//   2. lowest-index sprite core (RED|BLUE)
//   3. lowest-index sprite body (BLUE)
//   4. border, 8 px frame of 640x480 (RED), suppressed while flash_active && game
//   5. grass, y 360..363 inside the border (GREEN)
//   6. ground, y 364..471 (GREEN|BLUE)
//   7. black
// STRUCTURE
//  Package vga_pkg: sprite_mode_e enum; 12-bit colour constants; screen geometry localparams (640, 480, border 8, grass/ground rows).
//  Sub-module vga_sprite_hit: combinational body/core compare for one sprite.
//   - Instantiated NUM_SPRITES times in a generate loop.
//   - Its outputs are registered in stage 1 of this block.
// TESTING
//  1. rst mid-frame with sprites active: outputs and flash_active go 0 asynchronously; after release, all sprites stay OFF until written.
//  2. Write sprite 0 at (100,50), w=31, SHIP; pixel (116,55) reads RED|BLUE (0xF0F) 2 cycles later, but only after the next frame_start.
//  3. Overlap: sprites 1 and 3 both cover (200,60) with 1 = CORE and 3 = SHIP body; output is 0xF0F; the player at (200,60) overrides to 0xFF0.
//  4. game=1 with hit_pulse: border pixel (3,3) is black for exactly 30 frame_starts, then 0xF00; a second hit at frame 10 extends the flash to frame 40.
//  5. wr_en coincident with frame_start (idx 2, x=300): the old x is drawn this frame and x=300 next frame; wr_idx=7 with NUM_SPRITES=5 changes nothing.
//  6. Edge case x=0xFFF0, w=0x20: no wrap, no hit at x=5. BLINK mode toggles visibility every 8 frames with BLINK_SHIFT=3.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared sprite modes, colours and screen geometry for the VGA compositor.
package vga_pkg;
   typedef enum logic [1:0] {MODE_OFF, MODE_SHIP, MODE_CORE, MODE_BLINK} sprite_mode_e;
   localparam logic [11:0] COL_BLACK = 12'h000;
   localparam logic [11:0] COL_RED   = 12'hF00;
   localparam logic [11:0] COL_GREEN = 12'h0F0;
   localparam logic [11:0] COL_BLUE  = 12'h00F;
   localparam int SCR_W       = 640;
   localparam int SCR_H       = 480;
   localparam int BORDER      = 8;
   localparam int GRASS_Y0    = 360;
   localparam int GRASS_Y1    = 363;
   localparam int GROUND_Y0   = 364;
   localparam int GROUND_Y1   = 471;
   localparam int PLAYER_SIZE = 16;
   localparam int SHIP_H      = 10;
   localparam int CORE_HALF   = 4;
endpackage

// File: rtl/vga_sprite_hit.sv
// vga_sprite_hit: combinational body/core hit test of one pixel against one sprite.
module vga_sprite_hit import vga_pkg::*; #(
   parameter int COORD_W = 16
) (
   input  logic [COORD_W-1:0] xcoord,
   input  logic [COORD_W-1:0] ycoord,
   input  logic [COORD_W-1:0] sx,
   input  logic [COORD_W-1:0] sy,
   input  logic [COORD_W-1:0] sw,
   input  logic [1:0]         mode,
   input  logic               blink,
   output logic               body,
   output logic               core
);
   localparam logic [COORD_W:0] CH = (COORD_W+1)'(CORE_HALF);
   localparam logic [COORD_W:0] BH = (COORD_W+1)'(SHIP_H-1);
   logic [COORD_W:0] x, y, x0, y0, x1, y1, cx, cl;
   logic show_body, show_core;
   // One extra bit keeps right/bottom bounds from wrapping near the top of the coordinate range.
   assign x = {1'b0, xcoord};
   assign y = {1'b0, ycoord};
   assign x0 = {1'b0, sx};
   assign y0 = {1'b0, sy};
   assign x1 = x0 + {1'b0, sw};
   assign y1 = y0 + BH;
   assign cx = x0 + {2'b0, sw[COORD_W-1:1]};
   assign cl = cx >= CH ? cx - CH : '0;
   assign show_body = mode == MODE_SHIP || (mode == MODE_BLINK && blink);
   assign show_core = show_body || mode == MODE_CORE;
   assign body = show_body && x >= x0 && x <= x1 && y >= y0 && y <= y1;
   assign core = show_core && x >= cl && x <= cx + CH && y > y0 && y < y1;
endmodule

// File: rtl/vga_sprite_compositor.sv
// vga_sprite_compositor: two-stage pixel compositor for playfield, player and
// double-buffered ship sprites, with frame-driven blink and hit flash.
module vga_sprite_compositor import vga_pkg::*; #(
   parameter int NUM_SPRITES  = 5,
   parameter int COORD_W      = 16,
   parameter int FLASH_FRAMES = 30,
   parameter int BLINK_SHIFT  = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_valid,
   input  logic [COORD_W-1:0] xcoord,
   input  logic [COORD_W-1:0] ycoord,
   input  logic               frame_start,
   input  logic               game,
   input  logic               hit_pulse,
   input  logic [COORD_W-1:0] pxcoord,
   input  logic [COORD_W-1:0] pycoord,
   input  logic               wr_en,
   input  logic [3:0]         wr_idx,
   input  logic [COORD_W-1:0] wr_x,
   input  logic [COORD_W-1:0] wr_y,
   input  logic [COORD_W-1:0] wr_w,
   input  logic [1:0]         wr_mode,
   output logic               flash_active,
   output logic               rgb_valid,
   output logic [3:0]         vgaRed,
   output logic [3:0]         vgaGreen,
   output logic [3:0]         vgaBlue
);
   localparam int FW = $clog2(FLASH_FRAMES + 1);
   localparam logic [COORD_W-1:0] BL  = COORD_W'(BORDER);
   localparam logic [COORD_W-1:0] BR  = COORD_W'(SCR_W - BORDER);
   localparam logic [COORD_W-1:0] BB  = COORD_W'(SCR_H - BORDER);
   localparam logic [COORD_W-1:0] GS0 = COORD_W'(GRASS_Y0);
   localparam logic [COORD_W-1:0] GS1 = COORD_W'(GRASS_Y1);
   localparam logic [COORD_W-1:0] GD0 = COORD_W'(GROUND_Y0);
   localparam logic [COORD_W-1:0] GD1 = COORD_W'(GROUND_Y1);
   localparam logic [COORD_W:0]   PS  = (COORD_W+1)'(PLAYER_SIZE - 1);
   logic [COORD_W-1:0] sh_x [NUM_SPRITES];
   logic [COORD_W-1:0] sh_y [NUM_SPRITES];
   logic [COORD_W-1:0] sh_w [NUM_SPRITES];
   logic [1:0]         sh_m [NUM_SPRITES];
   logic [COORD_W-1:0] act_x [NUM_SPRITES];
   logic [COORD_W-1:0] act_y [NUM_SPRITES];
   logic [COORD_W-1:0] act_w [NUM_SPRITES];
   logic [1:0]         act_m [NUM_SPRITES];
   logic [7:0]             frame_cnt;
   logic [FW-1:0]          flash_cnt;
   logic [NUM_SPRITES-1:0] body, core, body_q, core_q;
   logic [COORD_W:0]       x, y, px, py;
   logic                   blink, player, border, grass, ground;
   logic                   player_q, border_q, grass_q, ground_q, v1, v2;
   logic [11:0]            colour, rgb_q;
   assign blink = frame_cnt[BLINK_SHIFT];
   assign flash_active = |flash_cnt;
   // Shadow copy uses the pre-edge shadow, so a coincident write lands one frame later.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            sh_x[i] <= '0;
            sh_y[i] <= '0;
            sh_w[i] <= '0;
            sh_m[i] <= MODE_OFF;
            act_x[i] <= '0;
            act_y[i] <= '0;
            act_w[i] <= '0;
            act_m[i] <= MODE_OFF;
         end
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (wr_en && wr_idx == 4'(i)) begin
               sh_x[i] <= wr_x;
               sh_y[i] <= wr_y;
               sh_w[i] <= wr_w;
               sh_m[i] <= wr_mode;
            end
            if (frame_start) begin
               act_x[i] <= sh_x[i];
               act_y[i] <= sh_y[i];
               act_w[i] <= sh_w[i];
               act_m[i] <= sh_m[i];
            end
         end
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         frame_cnt <= '0;
         flash_cnt <= '0;
      end else begin
         if (frame_start) frame_cnt <= frame_cnt + 8'd1;
         if (!game) flash_cnt <= '0;
         else if (hit_pulse) flash_cnt <= FW'(FLASH_FRAMES);
         else if (frame_start && flash_cnt != '0) flash_cnt <= flash_cnt - 1'b1;
      end
   for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
      vga_sprite_hit #(.COORD_W(COORD_W)) u_hit (
         .xcoord(xcoord), .ycoord(ycoord),
         .sx(act_x[i]), .sy(act_y[i]), .sw(act_w[i]), .mode(act_m[i]),
         .blink(blink), .body(body[i]), .core(core[i])
      );
   end
   assign x = {1'b0, xcoord};
   assign y = {1'b0, ycoord};
   assign px = {1'b0, pxcoord};
   assign py = {1'b0, pycoord};
   assign player = x >= px && x <= px + PS && y >= py && y <= py + PS;
   assign border = xcoord < BL || xcoord >= BR || ycoord < BL || ycoord >= BB;
   assign grass = !border && ycoord >= GS0 && ycoord <= GS1;
   assign ground = ycoord >= GD0 && ycoord <= GD1;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         body_q <= '0;
         core_q <= '0;
         player_q <= 1'b0;
         border_q <= 1'b0;
         grass_q <= 1'b0;
         ground_q <= 1'b0;
         v1 <= 1'b0;
      end else begin
         body_q <= body;
         core_q <= core;
         player_q <= player;
         border_q <= border && !(flash_active && game);
         grass_q <= grass;
         ground_q <= ground;
         v1 <= pix_valid;
      end
   // All cores share one colour and all bodies another, so any-set is the lowest-index winner.
   assign colour = player_q ? (COL_RED | COL_GREEN) :
                   |core_q  ? (COL_RED | COL_BLUE) :
                   |body_q  ? COL_BLUE :
                   border_q ? COL_RED :
                   grass_q  ? COL_GREEN :
                   ground_q ? (COL_GREEN | COL_BLUE) : COL_BLACK;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rgb_q <= '0;
         v2 <= 1'b0;
      end else begin
         rgb_q <= v1 ? colour : COL_BLACK;
         v2 <= v1;
      end
   assign rgb_valid = v2;
   assign vgaRed = rgb_q[11:8];
   assign vgaGreen = rgb_q[7:4];
   assign vgaBlue = rgb_q[3:0];
endmodule
